// File: rtl/ddr3_sweep_pkg.sv
// Shared types and helpers for the DDR3 trim sweep sequencer.
package ddr3_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WR,
        ST_WRESP,
        ST_RD,
        ST_RRESP,
        ST_REPORT
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Byte strobe to 32-bit bit mask: strobe bit b enables byte lane b.
    function automatic logic [31:0] expand_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/ddr3_sweep_cnt.sv
// Loadable down-counter with zero flag; holds at zero.
module ddr3_sweep_cnt #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ddr3_trim_sweep_ctrl.sv
// Trim sweep engine: per trim step, settle, write a pattern block over AXI,
// read it back, count masked mismatches and emit one result record.
module ddr3_trim_sweep_ctrl
    import ddr3_sweep_pkg::*;
#(
    parameter int          WORDS_PER_STEP = 16,
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter int          SETTLE_CYCLES  = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        sel_tras_i,
    input  logic [3:0]  trim_start_i,
    input  logic [3:0]  trim_end_i,
    input  logic [3:0]  fixed_trim_i,
    input  logic [3:0]  write_cycles_i,
    input  logic [31:0] pattern_i,
    input  logic [3:0]  wstrb_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        cfg_timing_en_o,
    output logic [3:0]  cfg_twr_trim_o,
    output logic [3:0]  cfg_tras_trim_o,
    output logic [3:0]  cfg_write_cycles_o,
    output logic        m_awvalid_o,
    output logic [31:0] m_awaddr_o,
    output logic [3:0]  m_awid_o,
    output logic [7:0]  m_awlen_o,
    output logic [1:0]  m_awburst_o,
    input  logic        m_awready_i,
    output logic        m_wvalid_o,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wstrb_o,
    output logic        m_wlast_o,
    input  logic        m_wready_i,
    input  logic        m_bvalid_i,
    input  logic [1:0]  m_bresp_i,
    input  logic [3:0]  m_bid_i,
    output logic        m_bready_o,
    output logic        m_arvalid_o,
    output logic [31:0] m_araddr_o,
    output logic [3:0]  m_arid_o,
    output logic [7:0]  m_arlen_o,
    output logic [1:0]  m_arburst_o,
    input  logic        m_arready_i,
    input  logic        m_rvalid_i,
    input  logic [31:0] m_rdata_i,
    input  logic [1:0]  m_rresp_i,
    input  logic [3:0]  m_rid_i,
    input  logic        m_rlast_i,
    output logic        m_rready_o,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [3:0]  res_trim_o,
    output logic [7:0]  res_errors_o
);

    state_e      state_d, state_q;
    logic [3:0]  trim_d, trim_q, end_d, end_q, fixed_d, fixed_q, wcyc_d, wcyc_q;
    logic [3:0]  wstrb_d, wstrb_q;
    logic        sel_d, sel_q, aw_done_d, aw_done_q, w_done_d, w_done_q, done_d, done_q;
    logic [7:0]  err_d, err_q;
    logic [31:0] pattern_d, pattern_q, addr_d, addr_q, wdata_d, wdata_q;
    logic        set_load, set_dec, set_zero, wrd_load, wrd_dec, wrd_zero, err_inc;
    logic        aw_hs, w_hs, ar_hs;

    ddr3_sweep_cnt #(.W(8)) u_settle_cnt (
        .clk_i(clk_i), .rst_ni(rst_ni), .load_i(set_load),
        .load_val_i(8'(SETTLE_CYCLES - 1)), .dec_i(set_dec), .zero_o(set_zero)
    );

    ddr3_sweep_cnt #(.W(8)) u_word_cnt (
        .clk_i(clk_i), .rst_ni(rst_ni), .load_i(wrd_load),
        .load_val_i(8'(WORDS_PER_STEP - 1)), .dec_i(wrd_dec), .zero_o(wrd_zero)
    );

    assign aw_hs = m_awvalid_o & m_awready_i;
    assign w_hs  = m_wvalid_o & m_wready_i;
    assign ar_hs = m_arvalid_o & m_arready_i;

    always_comb begin
        state_d   = state_q;
        trim_d    = trim_q;
        end_d     = end_q;
        fixed_d   = fixed_q;
        wcyc_d    = wcyc_q;
        wstrb_d   = wstrb_q;
        sel_d     = sel_q;
        pattern_d = pattern_q;
        addr_d    = addr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        done_d    = 1'b0;
        set_load  = 1'b0;
        set_dec   = 1'b0;
        wrd_load  = 1'b0;
        wrd_dec   = 1'b0;
        err_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    sel_d     = sel_tras_i;
                    trim_d    = trim_start_i;
                    end_d     = trim_end_i;
                    fixed_d   = fixed_trim_i;
                    wcyc_d    = write_cycles_i;
                    pattern_d = pattern_i;
                    wstrb_d   = wstrb_i;
                    err_d     = '0;
                    set_load  = 1'b1;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (set_zero) begin
                    wrd_load  = 1'b1;
                    addr_d    = ADDR_BASE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR;
                end else begin
                    set_dec = 1'b1;
                end
            end
            ST_WR: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_d = ST_WRESP;
            end
            ST_WRESP: begin
                if (m_bvalid_i) begin
                    err_inc = (m_bresp_i != AXI_RESP_OKAY);
                    if (wrd_zero) begin
                        wrd_load = 1'b1;
                        addr_d   = ADDR_BASE;
                        state_d  = ST_RD;
                    end else begin
                        wrd_dec   = 1'b1;
                        addr_d    = addr_q + 32'd4;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WR;
                    end
                end
            end
            ST_RD: begin
                if (ar_hs) state_d = ST_RRESP;
            end
            ST_RRESP: begin
                if (m_rvalid_i) begin
                    // one error per word, whether data or response is bad
                    err_inc = (((m_rdata_i ^ pattern_q ^ addr_q) & expand_mask(wstrb_q)) != '0)
                              || (m_rresp_i != AXI_RESP_OKAY);
                    if (wrd_zero) begin
                        state_d = ST_REPORT;
                    end else begin
                        wrd_dec = 1'b1;
                        addr_d  = addr_q + 32'd4;
                        state_d = ST_RD;
                    end
                end
            end
            ST_REPORT: begin
                if (res_ready_i) begin
                    if (trim_q == end_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        trim_d   = trim_q + 4'd1;
                        err_d    = '0;
                        set_load = 1'b1;
                        state_d  = ST_SETTLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
        wdata_d = pattern_d ^ addr_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            trim_q    <= '0;
            end_q     <= '0;
            fixed_q   <= '0;
            wcyc_q    <= '0;
            wstrb_q   <= '0;
            sel_q     <= 1'b0;
            pattern_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            trim_q    <= trim_d;
            end_q     <= end_d;
            fixed_q   <= fixed_d;
            wcyc_q    <= wcyc_d;
            wstrb_q   <= wstrb_d;
            sel_q     <= sel_d;
            pattern_q <= pattern_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign busy_o             = (state_q != ST_IDLE);
    assign done_o             = done_q;
    assign cfg_timing_en_o    = busy_o;
    assign cfg_twr_trim_o     = busy_o ? (sel_q ? fixed_q : trim_q) : 4'd0;
    assign cfg_tras_trim_o    = busy_o ? (sel_q ? trim_q : fixed_q) : 4'd0;
    assign cfg_write_cycles_o = busy_o ? wcyc_q : 4'd0;

    assign m_awvalid_o = (state_q == ST_WR) & ~aw_done_q;
    assign m_awaddr_o  = addr_q;
    assign m_awid_o    = 4'd0;
    assign m_awlen_o   = 8'd0;
    assign m_awburst_o = AXI_BURST_INCR;
    assign m_wvalid_o  = (state_q == ST_WR) & ~w_done_q;
    assign m_wdata_o   = wdata_q;
    assign m_wstrb_o   = wstrb_q;
    assign m_wlast_o   = 1'b1;
    assign m_bready_o  = (state_q == ST_WRESP);
    assign m_arvalid_o = (state_q == ST_RD);
    assign m_araddr_o  = addr_q;
    assign m_arid_o    = 4'd0;
    assign m_arlen_o   = 8'd0;
    assign m_arburst_o = AXI_BURST_INCR;
    assign m_rready_o  = (state_q == ST_RRESP);

    assign res_valid_o  = (state_q == ST_REPORT);
    assign res_trim_o   = trim_q;
    assign res_errors_o = err_q;

    // single-beat, single-ID traffic: IDs and rlast carry no information
    logic unused_ok;
    assign unused_ok = ^{m_bid_i, m_rid_i, m_rlast_i};

endmodule

// File: tb/tb_ddr3_trim_sweep_ctrl.sv
// Bench for ddr3_trim_sweep_ctrl: AXI memory slave with fault injection and
// a record-level reference model of the sweep.
module tb_ddr3_trim_sweep_ctrl;

    localparam int          WORDS  = 8;
    localparam int          SETTLE = 4;
    localparam logic [31:0] BASE   = 32'h0000_0100;

    logic clk_i = 1'b0, rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        start_i = 0, sel_tras_i = 0, res_ready_i = 0;
    logic [3:0]  trim_start_i = 0, trim_end_i = 0, fixed_trim_i = 0, write_cycles_i = 0, wstrb_i = 0;
    logic [31:0] pattern_i = 0;
    logic        busy_o, done_o, cfg_timing_en_o, res_valid_o;
    logic [3:0]  cfg_twr_trim_o, cfg_tras_trim_o, cfg_write_cycles_o, res_trim_o;
    logic [7:0]  res_errors_o;
    logic        m_awvalid_o, m_wvalid_o, m_wlast_o, m_bready_o, m_arvalid_o, m_rready_o;
    logic [31:0] m_awaddr_o, m_wdata_o, m_araddr_o;
    logic [3:0]  m_awid_o, m_wstrb_o, m_arid_o;
    logic [7:0]  m_awlen_o, m_arlen_o;
    logic [1:0]  m_awburst_o, m_arburst_o;
    logic        m_awready_i, m_wready_i, m_bvalid_i, m_arready_i, m_rvalid_i;
    logic [1:0]  m_bresp_i, m_rresp_i;
    logic [31:0] m_rdata_i;
    logic [3:0]  m_bid_i = 4'd0, m_rid_i = 4'd0;
    logic        m_rlast_i = 1'b1;

    ddr3_trim_sweep_ctrl #(.WORDS_PER_STEP(WORDS), .ADDR_BASE(BASE), .SETTLE_CYCLES(SETTLE)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .sel_tras_i(sel_tras_i),
        .trim_start_i(trim_start_i), .trim_end_i(trim_end_i), .fixed_trim_i(fixed_trim_i),
        .write_cycles_i(write_cycles_i), .pattern_i(pattern_i), .wstrb_i(wstrb_i),
        .busy_o(busy_o), .done_o(done_o), .cfg_timing_en_o(cfg_timing_en_o),
        .cfg_twr_trim_o(cfg_twr_trim_o), .cfg_tras_trim_o(cfg_tras_trim_o),
        .cfg_write_cycles_o(cfg_write_cycles_o),
        .m_awvalid_o(m_awvalid_o), .m_awaddr_o(m_awaddr_o), .m_awid_o(m_awid_o),
        .m_awlen_o(m_awlen_o), .m_awburst_o(m_awburst_o), .m_awready_i(m_awready_i),
        .m_wvalid_o(m_wvalid_o), .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
        .m_wlast_o(m_wlast_o), .m_wready_i(m_wready_i),
        .m_bvalid_i(m_bvalid_i), .m_bresp_i(m_bresp_i), .m_bid_i(m_bid_i), .m_bready_o(m_bready_o),
        .m_arvalid_o(m_arvalid_o), .m_araddr_o(m_araddr_o), .m_arid_o(m_arid_o),
        .m_arlen_o(m_arlen_o), .m_arburst_o(m_arburst_o), .m_arready_i(m_arready_i),
        .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i),
        .m_rid_i(m_rid_i), .m_rlast_i(m_rlast_i), .m_rready_o(m_rready_o),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_trim_o(res_trim_o), .res_errors_o(res_errors_o)
    );

    int checks = 0, errors = 0;

    // slave knobs, written only by the stimulus block
    logic        rand_rdy = 0, bresp_err = 0, corrupt_en = 0;
    logic [3:0]  corrupt_trim = 0;
    int          corrupt_word = 0;
    logic [31:0] corrupt_xor = 0;

    logic [31:0] mem [WORDS];
    logic        aw_got, w_got;
    logic [31:0] aw_addr_s, w_data_s;
    logic [3:0]  w_strb_s, cur_trim;
    int          aw_cnt, w_cnt, ar_cnt, r_cnt, widx, ridx;

    assign cur_trim = sel_tras_i ? cfg_tras_trim_o : cfg_twr_trim_o;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_awready_i <= 0; m_wready_i <= 0; m_bvalid_i <= 0; m_bresp_i <= 0;
            m_arready_i <= 0; m_rvalid_i <= 0; m_rdata_i <= 0; m_rresp_i <= 0;
            aw_got <= 0; w_got <= 0; aw_addr_s <= 0; w_data_s <= 0; w_strb_s <= 0;
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else begin
            m_awready_i <= rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            m_wready_i  <= rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            m_arready_i <= rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_awvalid_o && m_awready_i) begin
                aw_got <= 1; aw_addr_s <= m_awaddr_o; aw_cnt <= aw_cnt + 1;
            end
            if (m_wvalid_o && m_wready_i) begin
                w_got <= 1; w_data_s <= m_wdata_o; w_strb_s <= m_wstrb_o; w_cnt <= w_cnt + 1;
            end
            if (aw_got && w_got && !m_bvalid_i) begin
                widx = int'((aw_addr_s - BASE) >> 2) % WORDS;
                for (int b = 0; b < 4; b++)
                    if (w_strb_s[b]) mem[widx][8*b +: 8] <= w_data_s[8*b +: 8];
                m_bvalid_i <= 1;
                m_bresp_i  <= (bresp_err && aw_addr_s == BASE) ? 2'b10 : 2'b00;
                aw_got <= 0; w_got <= 0;
            end
            if (m_bvalid_i && m_bready_o) m_bvalid_i <= 0;
            if (m_arvalid_o && m_arready_i) begin
                ridx = int'((m_araddr_o - BASE) >> 2) % WORDS;
                ar_cnt <= ar_cnt + 1;
                m_rvalid_i <= 1;
                m_rresp_i  <= 2'b00;
                m_rdata_i  <= mem[ridx] ^ ((corrupt_en && cur_trim == corrupt_trim && ridx == corrupt_word)
                                           ? corrupt_xor : 32'd0);
            end
            if (m_rvalid_i && m_rready_o) begin
                m_rvalid_i <= 0; r_cnt <= r_cnt + 1;
            end
        end
    end

    initial begin aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a bad write response on word 0 costs one error; a read-side
    // corruption costs one more only if it touches a compared byte lane.
    function automatic int exp_errs(input logic [3:0] trim, input logic [3:0] strb);
        int e = 0;
        logic [31:0] m = 0;
        for (int b = 0; b < 4; b++) if (strb[b]) m = m | (32'hFF << (8 * b));
        if (bresp_err) e++;
        if (corrupt_en && trim == corrupt_trim && (corrupt_xor & m) != 0) e++;
        return e;
    endfunction

    task automatic run_sweep(input logic [3:0] ts, input logic [3:0] te, input logic sel,
                             input logic [3:0] fx, input logic [31:0] pat, input logic [3:0] strb,
                             input bit stall);
        logic [3:0] trims[$];
        logic [3:0] t, wc;
        int n, aw0, w0, ar0, r0;
        t = ts;
        for (int k = 0; k < 16; k++) begin
            trims.push_back(t);
            if (t == te) break;
            t = t + 4'd1;
        end
        aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt; r0 = r_cnt;
        wc = 4'($urandom_range(0, 15));
        @(negedge clk_i);
        sel_tras_i = sel; trim_start_i = ts; trim_end_i = te; fixed_trim_i = fx;
        pattern_i = pat; wstrb_i = strb; write_cycles_i = wc; start_i = 1;
        @(negedge clk_i);
        start_i = 0;
        chk("busy_after_start", 32'(busy_o), 32'd1);
        chk("cfg_en", 32'(cfg_timing_en_o), 32'd1);
        chk("cfg_wcyc", 32'(cfg_write_cycles_o), 32'(wc));
        n = 0;
        while (!m_awvalid_o && n < 100) begin @(negedge clk_i); n++; end
        chk("settle_latency", 32'(n), 32'(SETTLE));
        foreach (trims[i]) begin
            n = 0;
            while (!res_valid_o && n < 3000) begin @(negedge clk_i); n++; end
            chk("res_valid_seen", 32'(res_valid_o), 32'd1);
            chk("res_trim", 32'(res_trim_o), 32'(trims[i]));
            chk("res_errors", 32'(res_errors_o), 32'(exp_errs(trims[i], strb)));
            chk("cfg_twr", 32'(cfg_twr_trim_o), 32'(sel ? fx : trims[i]));
            chk("cfg_tras", 32'(cfg_tras_trim_o), 32'(sel ? trims[i] : fx));
            if (stall && i == 0) begin
                repeat (20) begin
                    @(negedge clk_i);
                    chk("stall_valid", 32'(res_valid_o), 32'd1);
                    chk("stall_trim", 32'(res_trim_o), 32'(trims[i]));
                    chk("stall_errors", 32'(res_errors_o), 32'(exp_errs(trims[i], strb)));
                    chk("stall_no_axi", 32'({m_awvalid_o, m_wvalid_o, m_arvalid_o}), 32'd0);
                end
            end
            res_ready_i = 1;
            @(negedge clk_i);
            res_ready_i = 0;
            if (i == trims.size() - 1) begin
                chk("done_pulse", 32'(done_o), 32'd1);
                chk("busy_end", 32'(busy_o), 32'd0);
                chk("cfg_idle", 32'({cfg_timing_en_o, cfg_twr_trim_o, cfg_tras_trim_o, cfg_write_cycles_o}), 32'd0);
                @(negedge clk_i);
                chk("done_one_cycle", 32'(done_o), 32'd0);
            end else begin
                chk("res_drop", 32'(res_valid_o), 32'd0);
                chk("busy_mid", 32'(busy_o), 32'd1);
                chk("no_early_done", 32'(done_o), 32'd0);
            end
        end
        chk("aw_beats", 32'(aw_cnt - aw0), 32'(trims.size() * WORDS));
        chk("w_beats", 32'(w_cnt - w0), 32'(trims.size() * WORDS));
        chk("ar_beats", 32'(ar_cnt - ar0), 32'(trims.size() * WORDS));
        chk("r_beats", 32'(r_cnt - r0), 32'(trims.size() * WORDS));
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_valids", 32'({m_awvalid_o, m_wvalid_o, m_arvalid_o, m_bready_o, m_rready_o, res_valid_o, done_o}), 32'd0);
        chk("rst_cfg", 32'({cfg_timing_en_o, cfg_twr_trim_o, cfg_tras_trim_o, cfg_write_cycles_o}), 32'd0);
        chk("rst_addr", m_awaddr_o, 32'd0);
        rst_ni = 1;

        // ideal memory, tWR sweep
        run_sweep(4'd2, 4'd4, 1'b0, 4'd9, 32'hA5A5_5A5A, 4'hF, 0);
        // corruption of byte 3, masked then unmasked
        corrupt_en = 1; corrupt_trim = 4'd3; corrupt_word = 5; corrupt_xor = 32'hFF00_0000;
        run_sweep(4'd2, 4'd4, 1'b0, 4'd9, 32'hA5A5_5A5A, 4'h7, 0);
        run_sweep(4'd2, 4'd4, 1'b0, 4'd9, 32'hA5A5_5A5A, 4'hF, 0);
        corrupt_en = 0;
        // wrap-around, tRAS sweep
        run_sweep(4'd14, 4'd1, 1'b1, 4'd6, 32'h1234_5678, 4'hF, 0);
        // random ready, bad bresp on word 0
        rand_rdy = 1; bresp_err = 1;
        run_sweep(4'd5, 4'd6, 1'b0, 4'd3, 32'hDEAD_BEEF, 4'hF, 0);
        bresp_err = 0;
        // result back-pressure
        run_sweep(4'd7, 4'd8, 1'b1, 4'd2, 32'h0F0F_F0F0, 4'hF, 1);
        // single step
        run_sweep(4'd11, 4'd11, 1'b0, 4'd0, 32'hCAFE_F00D, 4'h3, 0);

        // reset mid-write
        @(negedge clk_i);
        trim_start_i = 4'd1; trim_end_i = 4'd3; sel_tras_i = 0; start_i = 1;
        @(negedge clk_i);
        start_i = 0;
        n = 0;
        while (!m_awvalid_o && n < 100) begin @(negedge clk_i); n++; end
        chk("reset_test_reached_wr", 32'(m_awvalid_o), 32'd1);
        rst_ni = 0;
        #1;
        chk("midrst_valids", 32'({m_awvalid_o, m_wvalid_o, m_arvalid_o, m_bready_o, m_rready_o, res_valid_o, done_o}), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_cfg", 32'({cfg_timing_en_o, cfg_twr_trim_o, cfg_tras_trim_o, cfg_write_cycles_o}), 32'd0);
        chk("midrst_addr", m_awaddr_o, 32'd0);
        chk("midrst_data", m_wdata_o, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1;
        run_sweep(4'd0, 4'd1, 1'b0, 4'd5, 32'h5555_AAAA, 4'hF, 0);

        // randomized sweeps
        for (int it = 0; it < 4; it++) begin
            logic [3:0] ts;
            ts = 4'($urandom_range(0, 15));
            rand_rdy     = 1'($urandom_range(0, 1));
            bresp_err    = 1'($urandom_range(0, 1));
            corrupt_en   = 1;
            corrupt_trim = ts + 4'($urandom_range(0, 2));
            corrupt_word = $urandom_range(0, WORDS - 1);
            corrupt_xor  = 32'hFF << (8 * $urandom_range(0, 3));
            run_sweep(ts, ts + 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ddr3_trim_sweep_ctrl.md
# ddr3_trim_sweep_ctrl

Autonomous sweep sequencer that sits on the AXI slave port and timing-config inputs of the DDR3 AXI controller top level. For each trim value in a programmed range, it drives the controller's timing-trim configuration and waits a settle interval. It then writes a strobed test pattern to a block of words, reads the block back and counts byte-masked mismatches. It reports one result record per trim step over a valid/ready stream, which gives a self-contained tWR/tRAS margin characterisation engine.

## Interface
Parameters:
- WORDS_PER_STEP, 16, words written then read per trim step (1..256)
- ADDR_BASE, 32'h0000_0000, byte address of word 0; word i at ADDR_BASE + 4*i
- SETTLE_CYCLES, 8, idle cycles after each trim change before the first AXI request (1..255)

Ports (clock and reset first; reset is asynchronous and active-low, one clock):
- clk_i  in  1  sole clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  pulse; begins a sweep when idle
- sel_tras_i  in  1  0 = sweep cfg_twr_trim, 1 = sweep cfg_tras_trim
- trim_start_i  in  4  first trim value
- trim_end_i  in  4  last trim value
- fixed_trim_i  in  4  value held on the non-swept trim output
- write_cycles_i  in  4  passed to cfg_write_cycles_o
- pattern_i  in  32  base pattern
- wstrb_i  in  4  byte strobe for every write; also the compare mask
- busy_o  out  1  sweep in progress
- done_o  out  1  one-cycle pulse when the final result is accepted
- cfg_timing_en_o  out  1  high while busy
- cfg_twr_trim_o, cfg_tras_trim_o, cfg_write_cycles_o  out  4 each  timing config
- m_awvalid_o, m_awaddr_o[31:0], m_awid_o[3:0], m_awlen_o[7:0], m_awburst_o[1:0], m_awready_i  AXI write address
- m_wvalid_o, m_wdata_o[31:0], m_wstrb_o[3:0], m_wlast_o, m_wready_i  AXI write data
- m_bvalid_i, m_bresp_i[1:0], m_bid_i[3:0], m_bready_o  AXI write response
- m_arvalid_o, m_araddr_o[31:0], m_arid_o[3:0], m_arlen_o[7:0], m_arburst_o[1:0], m_arready_i  AXI read address
- m_rvalid_i, m_rdata_i[31:0], m_rresp_i[1:0], m_rid_i[3:0], m_rlast_i, m_rready_o  AXI read data
- res_valid_o, res_ready_i  out/in  1 each  result handshake
- res_trim_o  out  4  trim value of the record
- res_errors_o  out  8  mismatch count, saturating at 255

## Operation
- Constant outputs: awlen/arlen = 0, awburst/arburst = 2'b01 (INCR), awid/arid = 0, wlast = 1.
- Expected data for word i: pattern_i ^ awaddr. Byte mask M expands wstrb_i (bit b → byte b = 8'hFF).
- States: IDLE → SETTLE → WR → WRESP → (next word WR, or, after the last word, RD) → RRESP → (next word RD, or, after the last word, REPORT) → REPORT → SETTLE (next trim) or IDLE (final).
- IDLE: start_i latches all config inputs, sets trim = trim_start_i and clears the error counter. start_i while busy is ignored.
- SETTLE: counts SETTLE_CYCLES, then enters WR with word index = 0.
- WR: asserts awvalid and wvalid together. Each valid drops independently once accepted. Go to WRESP when both have been accepted.
- WRESP: bready = 1. A bresp other than OKAY adds 1 error.
- RRESP: rready = 1. An error is counted if ((rdata ^ expected) & M) != 0 or rresp != OKAY; at most 1 per word.
- REPORT: holds res_valid with stable fields until res_ready. If trim == trim_end, pulse done_o and go to IDLE. Otherwise trim = trim + 1 (mod 16), clear the counter and go to SETTLE.
- If trim_start > trim_end the sweep wraps 15 → 0. If start == end the sweep has a single step.
- Swept trim output = trim, the other trim output = fixed_trim_i. In IDLE all cfg outputs are 0 and cfg_timing_en_o = 0.
- wstrb_i = 0 gives a compare mask of 0, so only response errors count.

## Timing
- Reset values: every valid, ready, busy, done and cfg output = 0; data/address outputs = 0; state = IDLE.
- Reset asserted mid-transaction drops all valids immediately. Any outstanding AXI beat is abandoned; the bench must also reset the slave.
- start_i sampled at cycle t gives busy_o = 1 and new cfg values at t+1. The first awvalid is at t+1+SETTLE_CYCLES.
- Only one outstanding transaction at a time; the next request is issued no earlier than the cycle after the response handshake.
- Address and data are registered and are stable while valid is high (AXI rule).
- done_o and the return to IDLE occur in the cycle after the final res handshake. busy_o falls in that same cycle.

## Structure
- Shared package ddr3_sweep_pkg: state enum, AXI_RESP_OKAY constant, and the byte-mask expansion function.
- One sub-module, ddr3_sweep_cnt: a parameterised down-counter with load and zero flag, used for both the settle and word counters.

## Test plan
- Ideal memory model, twr sweep 2..4, pattern 32'hA5A5_5A5A, wstrb 4'hF → 3 records (trims 2, 3, 4), errors 0; done_o once; cfg_twr_trim_o steps 2, 3, 4; cfg_tras_trim_o = fixed_trim_i.
- Model corrupts byte 3 of word 5 at trim 3, wstrb 4'h7 → all errors 0 (masked). Repeat with wstrb 4'hF → trim 3 record errors = 1.
- Sweep 14..1 → records for trims 14, 15, 0, 1 in order.
- Slave randomly delays awready/wready independently and returns bresp 2'b10 on word 0 → no duplicate or lost beats; errors = 1.
- res_ready held low 20 cycles → res_valid and fields held stable, no AXI activity; release → next SETTLE.
- rst_ni pulsed low during WR → outputs reach reset values the same cycle; start_i after release runs a full sweep correctly.
